// File: rtl/gray_ptr_sync.sv
// Receives a Gray-coded pointer from another clock domain, resynchronises it and decodes it to binary.
// Flags each accepted change with a one-cycle strobe and step size. Multi-bit jumps set a sticky error.
module gray_ptr_sync #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             Clk_I,
  input  logic             Rst_I,
  input  logic [WIDTH-1:0] Gray_I,
  input  logic             Clr_I,
  output logic [WIDTH-1:0] Gray_O,
  output logic [WIDTH-1:0] Bin_O,
  output logic             Valid_O,
  output logic [WIDTH-1:0] Delta_O,
  output logic             Err_O,
  output logic             Ready_O
);

  localparam int CW = $clog2(SYNC_STAGES + 1);

  typedef enum logic [1:0] {PRIME, LOAD, TRACK} state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] r_gray, r_bin, r_delta;
  logic             r_valid, r_err, r_ready;
  logic [WIDTH-1:0] w_gray_nxt, w_bin_nxt, w_delta_nxt;
  logic             w_valid_nxt, w_err_nxt;
  logic [WIDTH-1:0] w_s, w_bin, w_diff;
  logic             w_multi;

  // Plain flop chain; nothing may sit between stages.
  always_ff @(posedge Clk_I or posedge Rst_I) begin
    if (Rst_I) begin
      for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
    end else begin
      r_sync[0] <= Gray_I;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
    end
  end

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_diff = w_s ^ r_gray;
  // More than one bit set iff clearing the lowest set bit leaves something.
  assign w_multi = (w_diff & (w_diff - WIDTH'(1))) != '0;

  always_comb begin
    w_bin = '0;
    for (int i = 0; i < WIDTH; i++) w_bin[i] = ^(w_s >> i);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_gray_nxt  = r_gray;
    w_bin_nxt   = r_bin;
    w_delta_nxt = r_delta;
    w_valid_nxt = 1'b0;
    w_err_nxt   = r_err & ~Clr_I;
    case (r_state)
      PRIME: begin
        if (r_cnt == CW'(SYNC_STAGES - 1)) begin
          w_state_nxt = LOAD;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      LOAD: begin
        w_gray_nxt  = w_s;
        w_bin_nxt   = w_bin;
        w_state_nxt = TRACK;
      end
      TRACK: begin
        if (w_diff != '0) begin
          w_gray_nxt  = w_s;
          w_bin_nxt   = w_bin;
          w_delta_nxt = w_bin - r_bin;
          w_valid_nxt = 1'b1;
          if (w_multi) w_err_nxt = 1'b1;
        end
      end
      default: w_state_nxt = PRIME;
    endcase
  end

  always_ff @(posedge Clk_I or posedge Rst_I) begin
    if (Rst_I) begin
      r_state <= PRIME;
      r_cnt   <= '0;
      r_gray  <= '0;
      r_bin   <= '0;
      r_delta <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_gray  <= w_gray_nxt;
      r_bin   <= w_bin_nxt;
      r_delta <= w_delta_nxt;
      r_valid <= w_valid_nxt;
      r_err   <= w_err_nxt;
      r_ready <= (r_state == TRACK);
    end
  end

  assign Gray_O  = r_gray;
  assign Bin_O   = r_bin;
  assign Delta_O = r_delta;
  assign Valid_O = r_valid;
  assign Err_O   = r_err;
  assign Ready_O = r_ready;

endmodule

// File: tb/tb_gray_ptr_sync.sv
// Directed bench for gray_ptr_sync at WIDTH=4, SYNC_STAGES=2; inputs change and outputs are sampled on the falling edge.
module tb_gray_ptr_sync;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] gray_in;
  logic       clr;
  logic [3:0] gray_o, bin_o, delta_o;
  logic       valid_o, err_o, ready_o;

  int errors = 0;
  int checks = 0;

  gray_ptr_sync #(.WIDTH(4), .SYNC_STAGES(2)) dut (
    .Clk_I  (clk),
    .Rst_I  (rst),
    .Gray_I (gray_in),
    .Clr_I  (clr),
    .Gray_O (gray_o),
    .Bin_O  (bin_o),
    .Valid_O(valid_o),
    .Delta_O(delta_o),
    .Err_O  (err_o),
    .Ready_O(ready_o)
  );

  always #5 clk = ~clk;

  task do_reset(input logic [3:0] g);
    @(negedge clk);
    rst = 1'b1; gray_in = g; clr = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task test_reset;
    int nval;
    rst = 1'b0; gray_in = 4'b0110; clr = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({gray_o, bin_o, delta_o, valid_o, err_o, ready_o} !== 15'd0) begin
      errors++; $display("FAIL reset_vals: got %h expected 0", {gray_o, bin_o, delta_o, valid_o, err_o, ready_o});
    end
    rst = 1'b0;
    nval = 0;
    for (int e = 1; e <= 4; e++) begin
      @(negedge clk);
      if (valid_o) nval++;
      if (e == 2) begin
        checks++;
        if (gray_o !== 4'd0 || ready_o !== 1'b0) begin
          errors++; $display("FAIL prime_hold: gray=%b ready=%b expected 0000/0", gray_o, ready_o);
        end
      end
      if (e == 3) begin
        checks++;
        if (gray_o !== 4'b0110 || bin_o !== 4'd4 || ready_o !== 1'b0) begin
          errors++; $display("FAIL load: gray=%b bin=%0d ready=%b expected 0110/4/0", gray_o, bin_o, ready_o);
        end
      end
      if (e == 4) begin
        checks++;
        if (ready_o !== 1'b1 || err_o !== 1'b0) begin
          errors++; $display("FAIL ready_rise: ready=%b err=%b expected 1/0", ready_o, err_o);
        end
      end
    end
    checks++;
    if (nval !== 0) begin
      errors++; $display("FAIL prime_no_valid: got %0d strobes expected 0", nval);
    end
  endtask

  task test_single_step;
    gray_in = 4'b0111;
    repeat (2) @(negedge clk);
    checks++;
    if (valid_o !== 1'b0 || bin_o !== 4'd4) begin
      errors++; $display("FAIL step_early: valid=%b bin=%0d expected 0/4", valid_o, bin_o);
    end
    @(negedge clk);
    checks++;
    if (valid_o !== 1'b1 || bin_o !== 4'd5 || delta_o !== 4'd1 || err_o !== 1'b0) begin
      errors++; $display("FAIL step: valid=%b bin=%0d delta=%0d err=%b expected 1/5/1/0", valid_o, bin_o, delta_o, err_o);
    end
    @(negedge clk);
    checks++;
    if (valid_o !== 1'b0 || bin_o !== 4'd5) begin
      errors++; $display("FAIL step_pulse: valid=%b bin=%0d expected 0/5", valid_o, bin_o);
    end
  endtask

  task test_sweep;
    logic [3:0] b;
    int n, total;
    do_reset(4'b0000);
    total = 0;
    for (int i = 1; i <= 16; i++) begin
      b = 4'(i);
      gray_in = b ^ (b >> 1);
      n = 0;
      repeat (4) begin
        @(negedge clk);
        if (valid_o) begin
          n++; total++;
          checks++;
          if (bin_o !== b || delta_o !== 4'd1) begin
            errors++; $display("FAIL sweep_%0d: bin=%0d delta=%0d expected %0d/1", i, bin_o, delta_o, b);
          end
        end
      end
      checks++;
      if (n !== 1) begin
        errors++; $display("FAIL sweep_strobe_%0d: got %0d strobes expected 1", i, n);
      end
    end
    checks++;
    if (total !== 16 || err_o !== 1'b0 || bin_o !== 4'd0) begin
      errors++; $display("FAIL sweep_total: strobes=%0d err=%b bin=%0d expected 16/0/0", total, err_o, bin_o);
    end
  endtask

  task test_multibit;
    gray_in = 4'b0011;
    repeat (3) @(negedge clk);
    checks++;
    if (valid_o !== 1'b1 || bin_o !== 4'd2 || delta_o !== 4'd2 || err_o !== 1'b1) begin
      errors++; $display("FAIL multi: valid=%b bin=%0d delta=%0d err=%b expected 1/2/2/1", valid_o, bin_o, delta_o, err_o);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (err_o !== 1'b1) begin
      errors++; $display("FAIL err_sticky: err=%b expected 1", err_o);
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checks++;
    if (err_o !== 1'b0) begin
      errors++; $display("FAIL err_clear: err=%b expected 0", err_o);
    end
    gray_in = 4'b0101;
    repeat (2) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checks++;
    if (valid_o !== 1'b1 || err_o !== 1'b1 || bin_o !== 4'd6 || delta_o !== 4'd4) begin
      errors++; $display("FAIL set_wins: valid=%b err=%b bin=%0d delta=%0d expected 1/1/6/4", valid_o, err_o, bin_o, delta_o);
    end
  endtask

  task test_stable;
    int bad;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      checks++;
      if ({valid_o, gray_o, bin_o, delta_o, err_o, ready_o} !== {1'b0, 4'b0101, 4'd6, 4'd4, 1'b1, 1'b1}) begin
        errors++; bad++;
        if (bad == 1) $display("FAIL stable: valid=%b gray=%b bin=%0d delta=%0d err=%b ready=%b expected 0/0101/6/4/1/1",
                               valid_o, gray_o, bin_o, delta_o, err_o, ready_o);
      end
    end
  endtask

  task test_midreset;
    int nval;
    gray_in = 4'b0111;
    repeat (4) @(negedge clk);
    checks++;
    if (bin_o !== 4'd5 || ready_o !== 1'b1) begin
      errors++; $display("FAIL pre_reset: bin=%0d ready=%b expected 5/1", bin_o, ready_o);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({gray_o, bin_o, delta_o, valid_o, err_o, ready_o} !== 15'd0) begin
      errors++; $display("FAIL async_clear: got %h expected 0", {gray_o, bin_o, delta_o, valid_o, err_o, ready_o});
    end
    #1 rst = 1'b0;
    nval = 0;
    for (int e = 1; e <= 6; e++) begin
      @(negedge clk);
      if (valid_o) nval++;
      if (e == 3) begin
        checks++;
        if (bin_o !== 4'd5 || gray_o !== 4'b0111 || ready_o !== 1'b0) begin
          errors++; $display("FAIL reprime_load: bin=%0d gray=%b ready=%b expected 5/0111/0", bin_o, gray_o, ready_o);
        end
      end
      if (e == 4) begin
        checks++;
        if (ready_o !== 1'b1 || err_o !== 1'b0) begin
          errors++; $display("FAIL reprime_ready: ready=%b err=%b expected 1/0", ready_o, err_o);
        end
      end
    end
    checks++;
    if (nval !== 0) begin
      errors++; $display("FAIL reprime_no_valid: got %0d strobes expected 0", nval);
    end
  endtask

  initial begin
    test_reset;
    test_single_step;
    test_sweep;
    test_multibit;
    test_stable;
    test_midreset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
